// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus tick-sampled debounce for the board switches.
// Produces the clean switch bus and one-cycle rise/fall pulses per bit.
module switch_debouncer #(
  parameter int WIDTH        = 16,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [DW-1:0]    div_cnt;
  logic [CW-1:0]    cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // A bit flips only after STABLE_TICKS consecutive disagreeing samples;
  // any agreeing sample in between restarts its count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_clean <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sw_rise <= '0;
      sw_fall <= '0;
      if (tick) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sync[i] == sw_clean[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            sw_clean[i] <= sync[i];
            sw_rise[i]  <= sync[i];
            sw_fall[i]  <= ~sync[i];
            cnt[i]      <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge
// monitor pops and compares them against two debouncer builds.
module tb_switch_debouncer;

  localparam int R = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw_raw = '0;
  logic [15:0] sw_raw1 = '0;
  logic [15:0] sw_clean, sw_rise, sw_fall;
  logic [15:0] sw_clean1, sw_rise1, sw_fall1;
  logic        tick, tick1;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    int          field;
    logic [15:0] mask;
    logic [15:0] value;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  switch_debouncer #(.WIDTH(16), .TICK_DIV(4), .STABLE_TICKS(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .sw_clean(sw_clean), .sw_rise(sw_rise), .sw_fall(sw_fall), .tick(tick)
  );

  switch_debouncer #(.WIDTH(16), .TICK_DIV(1), .STABLE_TICKS(3), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw1),
    .sw_clean(sw_clean1), .sw_rise(sw_rise1), .sw_fall(sw_fall1), .tick(tick1)
  );

  function automatic logic [15:0] fieldValue(int f);
    case (f)
      0: return sw_clean;
      1: return sw_rise;
      2: return sw_fall;
      3: return {15'b0, tick};
      4: return sw_clean1;
      5: return sw_rise1;
      6: return {15'b0, tick1};
      default: return sw_fall1;
    endcase
  endfunction

  task automatic pushExp(int t, int field, logic [15:0] mask, logic [15:0] value, string name);
    exp_t e;
    e.cyc = R + t;
    e.field = field;
    e.mask = mask;
    e.value = value;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput(exp_t e);
    logic [15:0] got;
    checks++;
    got = fieldValue(e.field) & e.mask;
    if (e.cyc != cyc) begin
      failures++;
      $display("[TB] FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
    end else if (got !== e.value) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", e.name, cyc, got, e.value);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic applyStimulus(int t, logic [15:0] raw, logic [15:0] raw1, logic rst_level);
    while (cyc < R + t) begin
      @(posedge clk);
      #1;
    end
    sw_raw  = raw;
    sw_raw1 = raw1;
    rst_n   = rst_level;
  endtask

  initial begin
    sw_raw = 16'hFFFF;
    pushExp(0, 0, 16'hFFFF, 16'h0000, "reset_clean");
    pushExp(0, 1, 16'hFFFF, 16'h0000, "reset_rise");
    pushExp(0, 2, 16'hFFFF, 16'h0000, "reset_fall");
    pushExp(0, 3, 16'h0001, 16'h0000, "reset_tick");
    pushExp(0, 4, 16'hFFFF, 16'h0000, "reset_clean1");
    pushExp(0, 6, 16'h0001, 16'h0000, "reset_tick1");
    pushExp(1, 3, 16'h0001, 16'h0000, "tick_c1");
    pushExp(1, 6, 16'h0001, 16'h0001, "tick1_c1");
    pushExp(2, 6, 16'h0001, 16'h0001, "tick1_c2");
    pushExp(3, 3, 16'h0001, 16'h0000, "tick_c3");
    pushExp(4, 3, 16'h0001, 16'h0001, "tick_c4");
    pushExp(5, 3, 16'h0001, 16'h0000, "tick_c5");
    pushExp(8, 3, 16'h0001, 16'h0001, "tick_c8");
    pushExp(12, 0, 16'hFFFF, 16'h0000, "por_clean_pre");
    pushExp(13, 0, 16'hFFFF, 16'hFFFF, "por_clean");
    pushExp(13, 1, 16'hFFFF, 16'hFFFF, "por_rise");
    pushExp(13, 2, 16'hFFFF, 16'h0000, "por_fall");
    pushExp(14, 1, 16'hFFFF, 16'h0000, "por_rise_end");
    pushExp(14, 0, 16'hFFFF, 16'hFFFF, "por_clean_hold");
    applyStimulus(0, 16'hFFFF, 16'h0000, 1'b1);

    // All bits fall; fast build sees a change on 4 bits
    applyStimulus(14, 16'h0000, 16'h00F0, 1'b1);
    pushExp(18, 4, 16'hFFFF, 16'h0000, "fast_clean_pre");
    pushExp(19, 4, 16'hFFFF, 16'h00F0, "fast_clean");
    pushExp(19, 5, 16'hFFFF, 16'h00F0, "fast_rise");
    pushExp(19, 7, 16'hFFFF, 16'h0000, "fast_fall");
    pushExp(20, 5, 16'hFFFF, 16'h0000, "fast_rise_end");
    pushExp(24, 0, 16'hFFFF, 16'hFFFF, "allfall_pre");
    pushExp(25, 0, 16'hFFFF, 16'h0000, "allfall_clean");
    pushExp(25, 2, 16'hFFFF, 16'hFFFF, "allfall_fall");
    pushExp(25, 1, 16'hFFFF, 16'h0000, "allfall_rise");
    pushExp(26, 2, 16'hFFFF, 16'h0000, "allfall_end");

    applyStimulus(26, 16'h0001, 16'h00F0, 1'b1);
    pushExp(36, 0, 16'hFFFF, 16'h0000, "b0_pre");
    pushExp(37, 0, 16'hFFFF, 16'h0001, "b0_clean");
    pushExp(37, 1, 16'hFFFF, 16'h0001, "b0_rise");
    pushExp(37, 2, 16'hFFFF, 16'h0000, "b0_fall");
    pushExp(38, 1, 16'hFFFF, 16'h0000, "b0_rise_end");

    applyStimulus(38, 16'h0000, 16'h00F0, 1'b1);
    pushExp(48, 0, 16'hFFFF, 16'h0001, "b0rel_pre");
    pushExp(49, 0, 16'hFFFF, 16'h0000, "b0rel_clean");
    pushExp(49, 2, 16'hFFFF, 16'h0001, "b0rel_fall");
    pushExp(49, 1, 16'hFFFF, 16'h0000, "b0rel_rise");
    pushExp(50, 2, 16'hFFFF, 16'h0000, "b0rel_end");

    // Bit 3 bounces low on the third sample, so the count restarts
    applyStimulus(50, 16'h0008, 16'h00F0, 1'b1);
    pushExp(58, 1, 16'h0008, 16'h0000, "bounce_rise_58");
    pushExp(62, 1, 16'h0008, 16'h0000, "bounce_rise_62");
    pushExp(66, 1, 16'h0008, 16'h0000, "bounce_rise_66");
    pushExp(70, 1, 16'h0008, 16'h0000, "bounce_rise_70");
    pushExp(72, 0, 16'h0008, 16'h0000, "bounce_clean_pre");
    pushExp(73, 0, 16'hFFFF, 16'h0008, "bounce_clean");
    pushExp(73, 1, 16'hFFFF, 16'h0008, "bounce_rise");
    pushExp(74, 1, 16'hFFFF, 16'h0000, "bounce_rise_end");
    applyStimulus(58, 16'h0000, 16'h00F0, 1'b1);
    applyStimulus(62, 16'h0008, 16'h00F0, 1'b1);

    // Two-cycle glitch on bit 7 that no sample ever sees
    applyStimulus(75, 16'h0088, 16'h00F0, 1'b1);
    pushExp(78, 1, 16'h0080, 16'h0000, "glitch_rise_78");
    pushExp(82, 0, 16'hFFFF, 16'h0008, "glitch_clean_82");
    pushExp(82, 1, 16'hFFFF, 16'h0000, "glitch_rise_82");
    pushExp(86, 0, 16'hFFFF, 16'h0008, "glitch_clean_86");
    applyStimulus(77, 16'h0008, 16'h00F0, 1'b1);

    applyStimulus(86, 16'h0000, 16'h00F0, 1'b1);
    pushExp(96, 0, 16'hFFFF, 16'h0008, "b3rel_pre");
    pushExp(97, 0, 16'hFFFF, 16'h0000, "b3rel_clean");
    pushExp(97, 2, 16'hFFFF, 16'h0008, "b3rel_fall");

    applyStimulus(98, 16'hA5A5, 16'h00F0, 1'b1);
    pushExp(108, 0, 16'hFFFF, 16'h0000, "a5_pre");
    pushExp(109, 0, 16'hFFFF, 16'hA5A5, "a5_clean");
    pushExp(109, 1, 16'hFFFF, 16'hA5A5, "a5_rise");
    pushExp(109, 2, 16'hFFFF, 16'h0000, "a5_fall");
    pushExp(110, 1, 16'hFFFF, 16'h0000, "a5_rise_end");

    applyStimulus(110, 16'h5A5A, 16'h00F0, 1'b1);
    pushExp(120, 0, 16'hFFFF, 16'hA5A5, "5a_pre");
    pushExp(121, 0, 16'hFFFF, 16'h5A5A, "5a_clean");
    pushExp(121, 1, 16'hFFFF, 16'h5A5A, "5a_rise");
    pushExp(121, 2, 16'hFFFF, 16'hA5A5, "5a_fall");
    pushExp(122, 1, 16'hFFFF, 16'h0000, "5a_rise_end");
    pushExp(122, 2, 16'hFFFF, 16'h0000, "5a_fall_end");

    // Bit 2 counts two samples, then a one-cycle reset discards the count
    applyStimulus(122, 16'h5A5E, 16'h00F0, 1'b1);
    pushExp(129, 0, 16'hFFFF, 16'h5A5A, "midrst_pre");
    pushExp(131, 0, 16'hFFFF, 16'h0000, "midrst_clean");
    pushExp(131, 1, 16'hFFFF, 16'h0000, "midrst_rise");
    pushExp(131, 2, 16'hFFFF, 16'h0000, "midrst_fall");
    pushExp(131, 3, 16'h0001, 16'h0000, "midrst_tick");
    pushExp(131, 4, 16'hFFFF, 16'h0000, "midrst_clean1");
    pushExp(131, 6, 16'h0001, 16'h0000, "midrst_tick1");
    pushExp(132, 6, 16'h0001, 16'h0001, "midrst_tick1_on");
    pushExp(133, 0, 16'hFFFF, 16'h0000, "midrst_no_old");
    pushExp(134, 3, 16'h0001, 16'h0000, "midrst_tick_off");
    pushExp(135, 3, 16'h0001, 16'h0001, "midrst_tick_on");
    pushExp(135, 4, 16'hFFFF, 16'h0000, "midrst_clean1_pre");
    pushExp(136, 4, 16'hFFFF, 16'h00F0, "midrst_clean1");
    pushExp(143, 0, 16'hFFFF, 16'h0000, "midrst_clean_pre");
    pushExp(144, 0, 16'hFFFF, 16'h5A5E, "midrst_clean_new");
    pushExp(144, 1, 16'hFFFF, 16'h5A5E, "midrst_rise_new");
    pushExp(145, 1, 16'hFFFF, 16'h0000, "midrst_rise_end");
    applyStimulus(130, 16'h5A5E, 16'h00F0, 1'b0);
    applyStimulus(131, 16'h5A5E, 16'h00F0, 1'b1);

    applyStimulus(150, 16'h5A5E, 16'h00F0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input conditioner that sits directly upstream of the memory-mapped switch/LED I/O device.
- Synchronises the raw, asynchronous board switch inputs to clk and debounces each bit.
- Drives the clean 16-bit switch bus that the I/O device returns on reads in the 0x7fe0–0x7fef switch window.
- Also produces one-cycle rise/fall event pulses per bit, for future interrupt or edge-capture logic.

Parameters:
- WIDTH, 16: number of switch bits.
- TICK_DIV, 1000: clk cycles per sample tick; must be >= 1.
- STABLE_TICKS, 4: consecutive ticks with the synced bit differing from sw_clean before sw_clean flips; must be >= 1.
- SYNC_STAGES, 2: synchroniser flop depth per bit; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- sw_raw  input  WIDTH  asynchronous raw switch levels.
- sw_clean  output  WIDTH  debounced levels; feeds the I/O device switches input.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_clean bit goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_clean bit goes 1->0.
- tick  output  1  sample-tick strobe, exported for debug/verification.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - All synchroniser flops, prescaler, per-bit counters, sw_clean, sw_rise, sw_fall and tick go to 0.
  - Reset takes priority over all other activity.
- Synchroniser:
  - Each sw_raw bit passes through SYNC_STAGES flops; the last stage is sync[i].
  - No logic sits between the stages.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is registered and is high for exactly one cycle each time the counter is at TICK_DIV-1.
  - The first tick occurs in cycle TICK_DIV after reset release.
  - With TICK_DIV=1, tick is high every cycle from the first cycle after reset.
- Per-bit debounce counter cnt[i], width clog2(STABLE_TICKS+1). Updated only on cycles where tick=1:
  - sync[i] == sw_clean[i]: cnt[i] <= 0 (a glitch or bounce restarts the count).
  - sync[i] != sw_clean[i] and cnt[i]+1 < STABLE_TICKS: cnt[i] <= cnt[i]+1.
  - sync[i] != sw_clean[i] and cnt[i]+1 == STABLE_TICKS: sw_clean[i] <= sync[i] and cnt[i] <= 0.
- Off-tick cycles: cnt and sw_clean hold. Changes between ticks are not observed.
- Edge pulses:
  - sw_rise[i] and sw_fall[i] are registered on the same edge that updates sw_clean[i].
  - A pulse is therefore high in the first cycle sw_clean[i] shows its new value, and low the next cycle.
  - sw_rise and sw_fall are never both high for the same bit.
- Bit independence: bits are fully independent. Any number of bits may flip and pulse in the same cycle.
- Latency (raw change to sw_clean change, raw held stable): between SYNC_STAGES + (STABLE_TICKS-1)*TICK_DIV + 1 and SYNC_STAGES + STABLE_TICKS*TICK_DIV cycles.
- Reset mid-operation:
  - Partial counts are discarded.
  - A switch held at 1 through reset produces sw_clean=1 and a sw_rise pulse after a full STABLE_TICKS ticks.
- No wrap-around of cnt is possible, because it clears on reaching STABLE_TICKS.

Test Plan (TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2, WIDTH=16 unless stated):
- Reset with sw_raw=16'hFFFF -> sw_clean, sw_rise, sw_fall, tick = 0 during reset; first tick in cycle 4 after release; sw_clean=16'hFFFF and sw_rise=16'hFFFF for one cycle on the 3rd tick; sw_fall stays 0.
- sw_raw[0] 0->1 held -> sw_clean[0] rises on the 3rd tick with synced value 1, with a one-cycle sw_rise[0]; no other bit changes; releasing to 0 for 3 ticks -> sw_fall[0] pulse and sw_clean[0]=0.
- Bounce: sw_raw[3] synced =1 at ticks 1 and 2, =0 at tick 3, =1 at ticks 4, 5, 6 -> sw_clean[3] stays 0 through tick 5 and rises only at tick 6; exactly one sw_rise[3] pulse.
- Sub-tick glitch: sw_raw[7] high for 2 cycles entirely between ticks -> sw_clean[7], sw_rise[7] and cnt unaffected.
- Multi-bit: sw_raw 16'h0000 -> 16'hA5A5 -> sw_clean=16'hA5A5 and sw_rise=16'hA5A5 in the same single cycle; then 16'hA5A5 -> 16'h5A5A -> sw_rise=16'h5A5A and sw_fall=16'hA5A5 in the same cycle.
- Reset mid-count: sw_raw[2]=1 for 2 ticks, then rst_n=0 for 1 cycle -> all outputs 0; after release, sw_clean[2] rises only on the 3rd new tick. Separate TICK_DIV=1 build: tick high every cycle, sw_clean follows a held input 2+3 cycles after the change.
